// File: rtl/inst_mem_pkg.sv
// Shared types and default widths for the instruction-memory responder.
package inst_mem_pkg;

   localparam int DEF_ADDR_WIDTH = 10;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int CNT_WIDTH      = 4;

   typedef struct packed {
      logic [DEF_DATA_WIDTH-1:0] data;
      logic                      err;
   } resp_t;

   typedef enum logic [0:0] {
      SLOT_IDLE = 1'b0,
      SLOT_WAIT = 1'b1
   } slot_state_e;

endpackage

// File: rtl/inst_mem_resp_fifo.sv
// Two-entry in-order response buffer; entry 0 is always the head, so the
// head output comes straight from a register.
module inst_mem_resp_fifo
   import inst_mem_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       push,
   input  resp_t      push_data,
   input  logic       pop,
   output resp_t      head,
   output logic       full,
   output logic       empty,
   output logic [1:0] count
);

   resp_t      ent0_q, ent0_d;
   resp_t      ent1_q, ent1_d;
   logic [1:0] cnt_q, cnt_d;
   logic [1:0] occ_after_pop;
   logic       do_pop, do_push;

   always_comb begin
      do_pop        = pop && (cnt_q != 2'd0);
      do_push       = push && ((cnt_q != 2'd2) || do_pop);
      occ_after_pop = cnt_q - {1'b0, do_pop};
      ent0_d        = ent0_q;
      ent1_d        = ent1_q;
      if (do_pop) begin
         ent0_d = ent1_q;
      end
      if (do_push) begin
         if (occ_after_pop == 2'd0) begin
            ent0_d = push_data;
         end else begin
            ent1_d = push_data;
         end
      end
      cnt_d = occ_after_pop + {1'b0, do_push};
      // A clear still lets the consumer take the current head this cycle.
      if (clear) begin
         cnt_d = 2'd0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ent0_q <= '0;
         ent1_q <= '0;
         cnt_q  <= 2'd0;
      end else begin
         ent0_q <= ent0_d;
         ent1_q <= ent1_d;
         cnt_q  <= cnt_d;
      end
   end

   assign head  = ent0_q;
   assign full  = (cnt_q == 2'd2);
   assign empty = (cnt_q == 2'd0);
   assign count = cnt_q;

endmodule

// File: rtl/inst_mem_responder.sv
// Memory side of the instruction fetch interface: one read slot with wait
// states feeding a 2-entry response FIFO. Define INST_MEM_PARITY_EN for parity.
module inst_mem_responder
   import inst_mem_pkg::*;
#(
   parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int WAIT_STATES = 0
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   output logic                  req_ready,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_data,
   output logic                  resp_err,
   input  logic                  resp_ready,
   input  logic                  flush,
   input  logic                  load_en,
   input  logic [ADDR_WIDTH-1:0] load_addr,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic                  load_par_inv,
   output logic                  busy
);

`ifdef INST_MEM_PARITY_EN
   localparam int MEM_W = DATA_WIDTH + 1;
`else
   localparam int MEM_W = DATA_WIDTH;
`endif

   logic [MEM_W-1:0] mem [2**ADDR_WIDTH];
   logic [MEM_W-1:0] wr_word;
   logic [MEM_W-1:0] rd_word;

   slot_state_e           state_q, state_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;

   logic       completing, accept, pop, push;
   logic [2:0] occ_next;
   resp_t      rd_resp, head;
   logic       fifo_full, fifo_empty;
   logic [1:0] fifo_count;

`ifdef INST_MEM_PARITY_EN
   assign wr_word = {(^load_data) ^ load_par_inv, load_data};
`else
   logic unused_par_inv;
   assign unused_par_inv = load_par_inv;
   assign wr_word        = load_data;
`endif

   always_ff @(posedge clk) begin
      if (load_en) begin
         mem[load_addr] <= wr_word;
      end
   end

   assign rd_word = mem[addr_q];

   always_comb begin
      rd_resp      = '0;
      rd_resp.data = DEF_DATA_WIDTH'(rd_word[DATA_WIDTH-1:0]);
`ifdef INST_MEM_PARITY_EN
      // Stored bit is data parity, so the XOR over the whole word flags a mismatch.
      rd_resp.err  = ^rd_word;
`else
      rd_resp.err  = 1'b0;
`endif
   end

   always_comb begin
      pop        = !fifo_empty && resp_ready;
      completing = (state_q == SLOT_WAIT) && (cnt_q == '0);
      occ_next   = {1'b0, fifo_count} + {2'b00, state_q == SLOT_WAIT} - {2'b00, pop};
      req_ready  = !reset && !flush && !load_en &&
                   ((state_q == SLOT_IDLE) || completing) && (occ_next < 3'd2);
      accept     = req_valid && req_ready;
      push       = completing && !flush;

      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      if (completing) begin
         state_d = SLOT_IDLE;
      end else if (state_q == SLOT_WAIT) begin
         cnt_d = cnt_q - CNT_WIDTH'(1);
      end
      if (accept) begin
         state_d = SLOT_WAIT;
         cnt_d   = CNT_WIDTH'(WAIT_STATES);
         addr_d  = req_addr;
      end
      if (flush) begin
         state_d = SLOT_IDLE;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= SLOT_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
      end
   end

   inst_mem_resp_fifo u_fifo (
      .clk       (clk),
      .reset     (reset),
      .clear     (flush),
      .push      (push),
      .push_data (rd_resp),
      .pop       (pop),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   logic unused_full;
   assign unused_full = fifo_full;

   assign resp_valid = !fifo_empty;
   assign resp_data  = DATA_WIDTH'(head.data);
   assign resp_err   = head.err;
   assign busy       = (state_q == SLOT_WAIT) || !fifo_empty;

endmodule

// File: tb/tb_inst_mem_responder.sv
// Directed bench: instance 0 has no wait states, instance 1 has three.
module tb_inst_mem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid    [2];
   logic [9:0]  req_addr     [2];
   logic        req_ready    [2];
   logic        resp_valid   [2];
   logic [31:0] resp_data    [2];
   logic        resp_err     [2];
   logic        resp_ready   [2];
   logic        flush        [2];
   logic        load_en      [2];
   logic [9:0]  load_addr    [2];
   logic [31:0] load_data    [2];
   logic        load_par_inv [2];
   logic        busy         [2];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      inst_mem_responder #(
         .ADDR_WIDTH  (10),
         .DATA_WIDTH  (32),
         .WAIT_STATES ((g == 0) ? 0 : 3)
      ) u_dut (
         .clk          (clk),
         .reset        (reset),
         .req_valid    (req_valid[g]),
         .req_addr     (req_addr[g]),
         .req_ready    (req_ready[g]),
         .resp_valid   (resp_valid[g]),
         .resp_data    (resp_data[g]),
         .resp_err     (resp_err[g]),
         .resp_ready   (resp_ready[g]),
         .flush        (flush[g]),
         .load_en      (load_en[g]),
         .load_addr    (load_addr[g]),
         .load_data    (load_data[g]),
         .load_par_inv (load_par_inv[g]),
         .busy         (busy[g])
      );
   end

`ifdef INST_MEM_PARITY_EN
   localparam logic PAR = 1'b1;
`else
   localparam logic PAR = 1'b0;
`endif

   typedef struct {
      logic        rv;
      logic [9:0]  ra;
      logic        rr;
      logic        le;
      logic [9:0]  la;
      logic [31:0] ld;
      logic        pi;
      logic        e_rdy;
      logic        e_vld;
      logic [31:0] e_data;
      logic        e_err;
   } vec_t;

   vec_t tbl[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic add(input logic rv, input logic [9:0] ra, input logic rr,
                      input logic le, input logic [9:0] la, input logic [31:0] ld,
                      input logic pi, input logic e_rdy, input logic e_vld,
                      input logic [31:0] e_data, input logic e_err);
      vec_t v;
      v = '{rv, ra, rr, le, la, ld, pi, e_rdy, e_vld, e_data, e_err};
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs(input int d);
      req_valid[d]    = 1'b0;
      req_addr[d]     = '0;
      resp_ready[d]   = 1'b0;
      flush[d]        = 1'b0;
      load_en[d]      = 1'b0;
      load_addr[d]    = '0;
      load_data[d]    = '0;
      load_par_inv[d] = 1'b0;
   endtask

   task automatic load_word(input int d, input logic [9:0] a, input logic [31:0] w);
      load_en[d]   = 1'b1;
      load_addr[d] = a;
      load_data[d] = w;
      cyc();
      load_en[d]   = 1'b0;
   endtask

   task automatic wait_valid(input int d, output int n);
      n = 0;
      while (!resp_valid[d] && n < 10) begin
         cyc();
         n++;
      end
   endtask

   initial begin
      int   n;
      logic stale;

      reset = 1'b1;
      idle_inputs(0);
      idle_inputs(1);
      cyc();
      cyc();
      chk("reset req_ready", req_ready[0], 0);
      chk("reset resp_valid", resp_valid[0], 0);
      chk("reset resp_data", resp_data[0], 0);
      chk("reset resp_err", resp_err[0], 0);
      chk("reset busy", busy[0], 0);
      chk("reset busy ws3", busy[1], 0);
      reset = 1'b0;
      cyc();

      // rv ra rr | le la ld pi | rdy vld data err
      add(1, 0, 1, 1, 0, 32'h3800_0000, 0, 0, 0, 32'h0, 0);
      add(0, 0, 1, 1, 1, 32'h3820_0001, 0, 0, 0, 32'h0, 0);
      add(0, 0, 1, 1, 5, 32'hDEAD_BEEF, 0, 0, 0, 32'h0, 0);
      add(1, 0, 1, 0, 0, 32'h0,         0, 1, 0, 32'h0, 0);
      add(1, 1, 1, 0, 0, 32'h0,         0, 1, 1, 32'h3800_0000, 0);
      add(0, 0, 1, 0, 0, 32'h0,         0, 1, 1, 32'h3820_0001, 0);
      add(0, 0, 1, 0, 0, 32'h0,         0, 1, 0, 32'h0, 0);
      add(1, 0, 0, 0, 0, 32'h0,         0, 1, 0, 32'h0, 0);
      add(1, 1, 0, 0, 0, 32'h0,         0, 1, 1, 32'h3800_0000, 0);
      add(1, 5, 0, 0, 0, 32'h0,         0, 0, 1, 32'h3800_0000, 0);
      add(1, 5, 0, 0, 0, 32'h0,         0, 0, 1, 32'h3800_0000, 0);
      add(1, 5, 1, 0, 0, 32'h0,         0, 1, 1, 32'h3820_0001, 0);
      add(0, 0, 1, 0, 0, 32'h0,         0, 1, 1, 32'hDEAD_BEEF, 0);
      add(0, 0, 1, 0, 0, 32'h0,         0, 1, 0, 32'h0, 0);
      add(0, 0, 1, 1, 7, 32'h1234_5678, 1, 0, 0, 32'h0, 0);
      add(1, 7, 1, 0, 0, 32'h0,         0, 1, 0, 32'h0, 0);
      add(1, 0, 1, 0, 0, 32'h0,         0, 1, 1, 32'h1234_5678, PAR);
      add(0, 0, 1, 0, 0, 32'h0,         0, 1, 1, 32'h3800_0000, 0);
      add(0, 0, 1, 0, 0, 32'h0,         0, 1, 0, 32'h0, 0);

      foreach (tbl[i]) begin
         req_valid[0]    = tbl[i].rv;
         req_addr[0]     = tbl[i].ra;
         resp_ready[0]   = tbl[i].rr;
         load_en[0]      = tbl[i].le;
         load_addr[0]    = tbl[i].la;
         load_data[0]    = tbl[i].ld;
         load_par_inv[0] = tbl[i].pi;
         #1;
         chk($sformatf("vec%0d req_ready", i), req_ready[0], tbl[i].e_rdy);
         cyc();
         chk($sformatf("vec%0d resp_valid", i), resp_valid[0], tbl[i].e_vld);
         if (tbl[i].e_vld) begin
            chk($sformatf("vec%0d resp_data", i), resp_data[0], tbl[i].e_data);
            chk($sformatf("vec%0d resp_err", i), resp_err[0], tbl[i].e_err);
         end
      end
      idle_inputs(0);

      // Wait-state latency on the WAIT_STATES=3 instance.
      load_word(1, 10'd5, 32'hDEAD_BEEF);
      load_word(1, 10'd2, 32'hCAFE_F00D);
      resp_ready[1] = 1'b1;
      req_valid[1]  = 1'b1;
      req_addr[1]   = 10'd5;
      #1;
      chk("ws3 accept ready", req_ready[1], 1);
      cyc();
      req_valid[1] = 1'b0;
      #1;
      for (int k = 0; k <= 4; k++) begin
         chk($sformatf("ws3 valid k%0d", k), resp_valid[1], 32'(k == 4));
         if (k < 4) begin
            chk($sformatf("ws3 ready k%0d", k), req_ready[1], 32'(k == 3));
            cyc();
            #1;
         end
      end
      chk("ws3 data", resp_data[1], 32'hDEAD_BEEF);
      cyc();
      chk("ws3 drained", resp_valid[1], 0);

      // Flush with one word buffered and one request in flight.
      resp_ready[1] = 1'b0;
      req_valid[1]  = 1'b1;
      req_addr[1]   = 10'd5;
      cyc();
      req_valid[1]  = 1'b0;
      wait_valid(1, n);
      chk("flush setup latency", n, 4);
      req_valid[1] = 1'b1;
      req_addr[1]  = 10'd2;
      #1;
      chk("flush setup ready", req_ready[1], 1);
      cyc();
      req_valid[1] = 1'b0;
      flush[1]     = 1'b1;
      req_valid[1] = 1'b1;
      #1;
      chk("flush ready", req_ready[1], 0);
      cyc();
      flush[1]     = 1'b0;
      req_valid[1] = 1'b0;
      chk("flush resp_valid", resp_valid[1], 0);
      chk("flush busy", busy[1], 0);
      resp_ready[1] = 1'b1;
      stale = 1'b0;
      for (int k = 0; k < 8; k++) begin
         cyc();
         if (resp_valid[1]) stale = 1'b1;
      end
      chk("flush no stale word", stale, 0);
      req_valid[1] = 1'b1;
      req_addr[1]  = 10'd2;
      cyc();
      req_valid[1] = 1'b0;
      wait_valid(1, n);
      chk("post-flush latency", n, 4);
      chk("post-flush data", resp_data[1], 32'hCAFE_F00D);
      chk("post-flush err", resp_err[1], 0);
      cyc();

      // Asynchronous reset with a word buffered.
      req_valid[0] = 1'b1;
      req_addr[0]  = 10'd1;
      cyc();
      req_valid[0] = 1'b0;
      cyc();
      chk("pre-reset valid", resp_valid[0], 1);
      #2;
      reset = 1'b1;
      #1;
      chk("async reset valid", resp_valid[0], 0);
      chk("async reset busy", busy[0], 0);
      chk("async reset data", resp_data[0], 0);
      chk("async reset ready", req_ready[0], 0);
      cyc();
      reset = 1'b0;
      cyc();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
